// File: rtl/ins_cache_ctrl.sv
// Single-window instruction cache for the PC's fetch stream.
// Serves addr_ins from a local RAM window and refills the window from DDR on a miss.
module ins_cache_ctrl #(
   parameter int ADDR_WIDTH_MEM  = 16,
   parameter int ISA_DEPTH       = 64,
   parameter int TOTAL_ISA_DEPTH = 128,
   parameter int INT_BASE        = 'hC000,
   parameter int ISA_WIDTH       = 32,
   parameter int DDR_ADDR_WIDTH  = 28
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
   output logic [ISA_WIDTH-1:0]      ins_out,
   output logic                      ins_out_valid,
   output logic                      ins_cache_rdy,
   output logic                      ins_cache_inited,
   output logic [9:0]                load_times,
   output logic                      ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
   input  logic                      ddr_rd_ack,
   input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
   input  logic                      ddr_rd_data_valid
);

   localparam int IDX_W = $clog2(ISA_DEPTH);
   localparam int BLK_W = ADDR_WIDTH_MEM - IDX_W;
   localparam logic [ADDR_WIDTH_MEM-1:0] TOTAL_LIM = ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);
   localparam logic [ADDR_WIDTH_MEM-1:0] INT_LIM   = ADDR_WIDTH_MEM'(INT_BASE);
   localparam logic [IDX_W-1:0]          LAST_BEAT = IDX_W'(ISA_DEPTH - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_REQ,
      S_RX,
      S_READY
   } state_t;

   state_t               state_q, state_d;
   logic [BLK_W-1:0]     tgt_q, tgt_d;
   logic [BLK_W-1:0]     cur_blk_q, cur_blk_d;
   logic [IDX_W-1:0]     beat_q, beat_d;
   logic [9:0]           load_times_q, load_times_d;
   logic                 inited_q, inited_d;
   logic                 valid_q, valid_d;
   logic [ISA_WIDTH-1:0] ins_q;
   logic [ISA_WIDTH-1:0] ram_q [ISA_DEPTH];

   logic [BLK_W-1:0]     addr_blk;
   logic [IDX_W-1:0]     addr_idx;
   logic                 addr_ok;
   logic                 miss;
   logic                 ram_we;

   // load_times is 10 bits wide while the window index may reach 1023.
   function automatic logic [9:0] sat_load_times(input logic [BLK_W-1:0] blk);
      int unsigned nxt;
      nxt = 32'(blk) + 32'd1;
      return (nxt > 32'd1023) ? 10'd1023 : nxt[9:0];
   endfunction

   assign addr_blk = addr_ins[ADDR_WIDTH_MEM-1:IDX_W];
   assign addr_idx = addr_ins[IDX_W-1:0];
   assign addr_ok  = (addr_ins < TOTAL_LIM) || (addr_ins >= INT_LIM);
   assign miss     = addr_ok && (addr_blk != cur_blk_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_INIT;
         tgt_q        <= '0;
         cur_blk_q    <= '0;
         beat_q       <= '0;
         load_times_q <= '0;
         inited_q     <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         cur_blk_q    <= cur_blk_d;
         beat_q       <= beat_d;
         load_times_q <= load_times_d;
         inited_q     <= inited_d;
         valid_q      <= valid_d;
      end
   end

   // The refill target is latched at miss time; addr_ins is not looked at again until READY.
   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      cur_blk_d    = cur_blk_q;
      beat_d       = beat_q;
      load_times_d = load_times_q;
      inited_d     = inited_q;
      valid_d      = 1'b0;
      ram_we       = 1'b0;
      unique case (state_q)
         S_INIT: begin
            tgt_d   = '0;
            state_d = S_REQ;
         end
         S_REQ: begin
            if (ddr_rd_ack) state_d = S_RX;
         end
         S_RX: begin
            if (ddr_rd_data_valid) begin
               ram_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  cur_blk_d    = tgt_q;
                  load_times_d = sat_load_times(tgt_q);
                  beat_d       = '0;
                  inited_d     = 1'b1;
                  state_d      = S_READY;
               end
            end
         end
         S_READY: begin
            if (miss) begin
               tgt_d   = addr_blk;
               state_d = S_REQ;
            end else begin
               valid_d = addr_ok;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ins_q <= '0;
      end else if (state_q == S_READY) begin
         ins_q <= ram_q[addr_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[beat_q] <= ddr_rd_data;
   end

   // Handshake outputs decode the state directly so a reset drops them without waiting for a clock.
   assign ddr_rd_req       = (state_q == S_REQ);
   assign ddr_rd_addr      = DDR_ADDR_WIDTH'({tgt_q, {(IDX_W + 3){1'b0}}});
   assign ins_cache_rdy    = (state_q == S_READY);
   assign ins_cache_inited = inited_q;
   assign load_times       = load_times_q;
   assign ins_out          = ins_q;
   assign ins_out_valid    = valid_q;

   assert property (@(posedge clk) disable iff (!rst) !(ddr_rd_req && ins_cache_rdy));
   assert property (@(posedge clk) disable iff (!rst) ins_out_valid |-> ins_cache_inited);

endmodule

// File: tb/tb_ins_cache_ctrl.sv
// Randomized scoreboard bench for ins_cache_ctrl with a behavioural DDR responder.
// Expected instructions come from the address-to-word rule; expected refills from a window model.
module tb_ins_cache_ctrl;

   localparam int ISA_DEPTH = 64;

   logic        clk;
   logic        rst;
   logic [15:0] addr_ins;
   logic [31:0] ins_out;
   logic        ins_out_valid;
   logic        ins_cache_rdy;
   logic        ins_cache_inited;
   logic [9:0]  load_times;
   logic        ddr_rd_req;
   logic [27:0] ddr_rd_addr;
   logic        ddr_rd_ack;
   logic [31:0] ddr_rd_data;
   logic        ddr_rd_data_valid;

   ins_cache_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .addr_ins          (addr_ins),
      .ins_out           (ins_out),
      .ins_out_valid     (ins_out_valid),
      .ins_cache_rdy     (ins_cache_rdy),
      .ins_cache_inited  (ins_cache_inited),
      .load_times        (load_times),
      .ddr_rd_req        (ddr_rd_req),
      .ddr_rd_addr       (ddr_rd_addr),
      .ddr_rd_ack        (ddr_rd_ack),
      .ddr_rd_data       (ddr_rd_data),
      .ddr_rd_data_valid (ddr_rd_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          cls;
      logic [31:0] w;
      int          a;
   } exp_t;

   exp_t sbq[$];
   int   exp_req[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   hits = 0;
   int   last_hit_addr = -1;
   int   model_blk = -1;
   int   beat_no = 0;
   int   bursts = 0;
   int   ack_dly = 3;
   int   spur_n = 0;

   // DDR content: instruction address a holds this word.
   function automatic logic [31:0] word(input int a);
      return 32'h1000 + 32'(a) + (32'(a) << 16);
   endfunction

   function automatic bit valid_class(input int a);
      return (a < 128) || (a >= 'hC000);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drives a new PC address and records which refill the cache owes for it.
   task automatic set_addr(input logic [15:0] a);
      int b;
      b = int'(a) / ISA_DEPTH;
      addr_ins = a;
      if (valid_class(int'(a)) && b != model_blk) begin
         exp_req.push_back(b);
         model_blk = b;
      end
   endtask

   task automatic access(input logic [15:0] a);
      int h0;
      int t;
      h0 = hits;
      set_addr(a);
      t = 0;
      while (!(hits > h0 && last_hit_addr == int'(a)) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk($sformatf("hit_%0h", a), 32'(t < 2000), 32'd1);
   endtask

   // Records the address the DUT samples at each edge.
   initial begin : recorder
      exp_t e;
      forever begin
         @(posedge clk);
         e.cls = valid_class(int'(addr_ins));
         e.w   = word(int'(addr_ins));
         e.a   = int'(addr_ins);
         sbq.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (ins_out_valid) begin
               n_checks++;
               if (!e.cls || ins_out !== e.w) begin
                  n_fail++;
                  $display("FAIL ins_out addr=%0h: got %0h with valid=1, expected %0h valid=%0d",
                           e.a, ins_out, e.w, e.cls);
               end else begin
                  hits++;
                  last_hit_addr = e.a;
               end
            end
         end
      end
   end

   initial begin : ddr_model
      int          d;
      int          b;
      logic [27:0] base;
      ddr_rd_ack = 1'b0;
      ddr_rd_data_valid = 1'b0;
      ddr_rd_data = '0;
      forever begin
         @(negedge clk);
         ddr_rd_ack = 1'b0;
         ddr_rd_data_valid = 1'b0;
         if (rst && ddr_rd_req) begin
            d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            chk("req_held", 32'(ddr_rd_req), 32'd1);
            base = ddr_rd_addr;
            if (exp_req.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_req: got addr %0h, expected no request", base);
            end else begin
               b = exp_req.pop_front();
               chk("ddr_rd_addr", 32'(base), 32'(b * ISA_DEPTH * 8));
            end
            ddr_rd_ack = 1'b1;
            beat_no = 0;
            bursts++;
            @(negedge clk);
            ddr_rd_ack = 1'b0;
            while (beat_no < ISA_DEPTH && rst) begin
               if ($urandom_range(0, 3) == 0) begin
                  ddr_rd_data_valid = 1'b0;
                  ddr_rd_data = 32'hBAD0BAD0;
               end else begin
                  ddr_rd_data_valid = 1'b1;
                  ddr_rd_data = word(int'(base) / 8 + beat_no);
               end
               @(negedge clk);
               if (ddr_rd_data_valid) beat_no++;
            end
            ddr_rd_data_valid = 1'b0;
         end else if (spur_n > 0) begin
            ddr_rd_ack = 1'b1;
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data = 32'hDEADBEEF;
            spur_n--;
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          t;
      int          b0;
      int          r;
      logic [15:0] a;
      rst = 1'b0;
      addr_ins = '0;
      #2;
      chk("rst_rdy", 32'(ins_cache_rdy), 32'd0);
      chk("rst_inited", 32'(ins_cache_inited), 32'd0);
      chk("rst_load_times", 32'(load_times), 32'd0);
      chk("rst_req", 32'(ddr_rd_req), 32'd0);
      chk("rst_valid", 32'(ins_out_valid), 32'd0);
      chk("rst_ins_out", ins_out, 32'd0);
      chk("rst_ddr_addr", 32'(ddr_rd_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      set_addr(16'd0);
      rst = 1'b1;

      t = 0;
      while (!ins_cache_rdy && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("init_rdy", 32'(ins_cache_rdy), 32'd1);
      chk("init_inited", 32'(ins_cache_inited), 32'd1);
      chk("init_load_times", 32'(load_times), 32'd1);
      ack_dly = -1;
      access(16'd5);

      set_addr(16'd64);
      @(posedge clk); #1;
      chk("miss_rdy_drop", 32'(ins_cache_rdy), 32'd0);
      chk("miss_req", 32'(ddr_rd_req), 32'd1);
      chk("miss_ddr_addr", 32'(ddr_rd_addr), 32'd512);
      access(16'd64);
      chk("blk1_load_times", 32'(load_times), 32'd2);
      chk("blk1_rdy", 32'(ins_cache_rdy), 32'd1);

      foreach (exp_req[i]) chk("no_pending_before_park", 32'(exp_req[i]), 32'hFFFFFFFF);
      set_addr(16'h8000);
      repeat (4) @(posedge clk);
      #1;
      chk("park_rdy", 32'(ins_cache_rdy), 32'd1);
      chk("park_valid", 32'(ins_out_valid), 32'd0);
      chk("park_req", 32'(ddr_rd_req), 32'd0);
      access(16'hC003);
      chk("int_load_times", 32'(load_times), 32'd769);

      b0 = bursts;
      set_addr(16'd64);
      t = 0;
      while (!(bursts > b0 && beat_no >= 10) && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("midrx_reached", 32'(t < 1000), 32'd1);
      set_addr(16'd3);
      access(16'd3);
      chk("midrx_load_times", 32'(load_times), 32'd1);
      chk("midrx_reqs_done", 32'(exp_req.size()), 32'd0);

      spur_n = 6;
      t = 0;
      while (spur_n > 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("spur_rdy", 32'(ins_cache_rdy), 32'd1);
      chk("spur_req", 32'(ddr_rd_req), 32'd0);
      chk("spur_load_times", 32'(load_times), 32'd1);
      for (int i = 0; i < ISA_DEPTH; i += 9) access(16'(i));
      access(16'd63);

      b0 = bursts;
      set_addr(16'd64);
      t = 0;
      while (!(bursts > b0 && beat_no >= 20) && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rstmid_reached", 32'(t < 1000), 32'd1);
      rst = 1'b0;
      #1;
      chk("rstmid_req", 32'(ddr_rd_req), 32'd0);
      chk("rstmid_rdy", 32'(ins_cache_rdy), 32'd0);
      chk("rstmid_inited", 32'(ins_cache_inited), 32'd0);
      chk("rstmid_load_times", 32'(load_times), 32'd0);
      model_blk = -1;
      set_addr(16'd5);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      access(16'd5);
      chk("rstmid_relinit", 32'(ins_cache_inited), 32'd1);

      access(16'hFFFF);
      chk("sat_load_times", 32'(load_times), 32'd1023);

      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6) a = 16'($urandom_range(0, 127));
         else if (r < 8) a = 16'(32'hC000 + $urandom_range(0, 255));
         else a = 16'($urandom_range(32'h0080, 32'hBFFF));
         if (valid_class(int'(a))) begin
            access(a);
            chk("rnd_load_times", 32'(load_times), 32'(int'(a) / ISA_DEPTH + 1));
         end else begin
            set_addr(a);
            repeat (3) @(posedge clk);
            #1;
            chk("rnd_park_rdy", 32'(ins_cache_rdy), 32'd1);
            chk("rnd_park_req", 32'(ddr_rd_req), 32'd0);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("final_reqs_done", 32'(exp_req.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
